// File: rtl/decomp_fetch_seq_pkg.sv
// Shared types and constants for the decompressing fetch sequencer.
package decomp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RESP  = 3'd2,
    LOOK0 = 3'd3,
    HOLD  = 3'd4,
    LOOK1 = 3'd5
  } stateT;

  localparam int unsigned ENC_BIT   = 31;
  localparam int unsigned HALF_OFS  = 16;
  localparam int unsigned PC_STRIDE = 4;

endpackage

// File: rtl/decomp_fetch_seq_perf_cnt.sv
// Saturating counters of delivered raw and decompressed instructions.
module decomp_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        rawInc,
  input  logic        cmpInc,
  output logic [31:0] perf_raw_cnt,
  output logic [31:0] perf_cmp_cnt
);

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_raw_cnt <= 32'd0;
      perf_cmp_cnt <= 32'd0;
    end else begin
      if (rawInc && (perf_raw_cnt != 32'hFFFF_FFFF)) begin
        perf_raw_cnt <= perf_raw_cnt + 32'd1;
      end else begin
        perf_raw_cnt <= perf_raw_cnt;
      end
      if (cmpInc && (perf_cmp_cnt != 32'hFFFF_FFFF)) begin
        perf_cmp_cnt <= perf_cmp_cnt + 32'd1;
      end else begin
        perf_cmp_cnt <= perf_cmp_cnt;
      end
    end
  end

endmodule

// File: rtl/decomp_fetch_seq.sv
// Instruction fetch sequencer expanding compressed pairs through a lookup table.
// Define DECOMP_PERF_CNT_EN to add the perf_raw_cnt / perf_cmp_cnt counter outputs.
module decomp_fetch_seq
  import decomp_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter int unsigned          IDX_W    = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_branch,
  input  logic [ADDR_W-1:0]  cpu_target,
  output logic               cpu_valid,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_data,
  output logic               tbl_re,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [INSTR_W-1:0] tbl_data,
  output logic               busy
`ifdef DECOMP_PERF_CNT_EN
  ,
  output logic [31:0]        perf_raw_cnt,
  output logic [31:0]        perf_cmp_cnt
`endif
);

  stateT               stateR, nextStateS;
  logic [ADDR_W-1:0]   pcR, pcNextS;
  logic [IDX_W-1:0]    idx1R, idx1NextS;
  logic [INSTR_W-1:0]  wordR, wordNextS;
  logic                redirValidR, redirValidNextS;
  logic [ADDR_W-1:0]   redirTargetR, redirTargetNextS;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateR       <= IDLE;
      pcR          <= RESET_PC;
      idx1R        <= '0;
      wordR        <= '0;
      redirValidR  <= 1'b0;
      redirTargetR <= '0;
    end else begin
      stateR       <= nextStateS;
      pcR          <= pcNextS;
      idx1R        <= idx1NextS;
      wordR        <= wordNextS;
      redirValidR  <= redirValidNextS;
      redirTargetR <= redirTargetNextS;
    end
  end

  // Next-state and output decode.
  always_comb begin
    nextStateS       = stateR;
    pcNextS          = pcR;
    idx1NextS        = idx1R;
    wordNextS        = wordR;
    redirValidNextS  = redirValidR;
    redirTargetNextS = redirTargetR;
    mem_req          = 1'b0;
    mem_addr         = '0;
    tbl_re           = 1'b0;
    tbl_idx          = '0;
    cpu_valid        = 1'b0;
    cpu_instr        = '0;
    case (stateR)
      IDLE: begin
        if (cpu_branch) begin
          pcNextS   = cpu_target;
          idx1NextS = '0;
        end else if (cpu_req) begin
          nextStateS = FETCH;
        end else begin
          nextStateS = IDLE;
        end
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pcR;
        if (mem_ack) begin
          // A redirect seen during the access drops the returned word entirely.
          if (cpu_branch || redirValidR) begin
            pcNextS         = cpu_branch ? cpu_target : redirTargetR;
            redirValidNextS = 1'b0;
            nextStateS      = IDLE;
          end else if (mem_data[ENC_BIT]) begin
            tbl_re     = 1'b1;
            tbl_idx    = mem_data[IDX_W-1:0];
            idx1NextS  = mem_data[HALF_OFS +: IDX_W];
            nextStateS = LOOK0;
          end else begin
            wordNextS  = INSTR_W'(mem_data);
            nextStateS = RESP;
          end
        end else if (cpu_branch) begin
          redirValidNextS  = 1'b1;
          redirTargetNextS = cpu_target;
        end else begin
          nextStateS = FETCH;
        end
      end
      RESP: begin
        nextStateS = IDLE;
        if (cpu_branch) begin
          pcNextS = cpu_target;
        end else begin
          cpu_valid = 1'b1;
          cpu_instr = wordR;
          pcNextS   = pcR + ADDR_W'(PC_STRIDE);
        end
      end
      LOOK0: begin
        if (cpu_branch) begin
          pcNextS    = cpu_target;
          idx1NextS  = '0;
          nextStateS = IDLE;
        end else begin
          cpu_valid  = 1'b1;
          cpu_instr  = tbl_data;
          nextStateS = HOLD;
        end
      end
      HOLD: begin
        if (cpu_branch) begin
          pcNextS    = cpu_target;
          idx1NextS  = '0;
          nextStateS = IDLE;
        end else if (cpu_req) begin
          tbl_re     = 1'b1;
          tbl_idx    = idx1R;
          nextStateS = LOOK1;
        end else begin
          nextStateS = HOLD;
        end
      end
      LOOK1: begin
        nextStateS = IDLE;
        idx1NextS  = '0;
        if (cpu_branch) begin
          pcNextS = cpu_target;
        end else begin
          cpu_valid = 1'b1;
          cpu_instr = tbl_data;
          pcNextS   = pcR + ADDR_W'(PC_STRIDE);
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // HOLD is a parked state waiting on the CPU, so it does not count as busy.
  always_comb begin
    busy = (stateR != IDLE) && (stateR != HOLD);
  end

`ifdef DECOMP_PERF_CNT_EN
  logic rawIncS, cmpIncS;

  // Attribute each delivered instruction to its source.
  always_comb begin
    rawIncS = cpu_valid && (stateR == RESP);
    cmpIncS = cpu_valid && ((stateR == LOOK0) || (stateR == LOOK1));
  end

  decomp_perf_cnt uPerfCnt (
    .clk          (clk),
    .reset        (reset),
    .rawInc       (rawIncS),
    .cmpInc       (cmpIncS),
    .perf_raw_cnt (perf_raw_cnt),
    .perf_cmp_cnt (perf_cmp_cnt)
  );
`endif

endmodule

// File: tb/tb_decomp_fetch_seq.sv
// Scoreboard bench for decomp_fetch_seq with a registered decompression-table model.
module tb_decomp_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_branch;
  logic [31:0] cpu_target;
  logic        cpu_valid;
  logic [31:0] cpu_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        tbl_re;
  logic [7:0]  tbl_idx;
  logic [31:0] tbl_data;
  logic        busy;
`ifdef DECOMP_PERF_CNT_EN
  logic [31:0] perf_raw_cnt, perf_cmp_cnt;
  logic [31:0] rawBase;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];

  decomp_fetch_seq #(.ADDR_W(32), .INSTR_W(32), .IDX_W(8), .RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_branch (cpu_branch),
    .cpu_target (cpu_target),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .tbl_re     (tbl_re),
    .tbl_idx    (tbl_idx),
    .tbl_data   (tbl_data),
    .busy       (busy)
`ifdef DECOMP_PERF_CNT_EN
    ,
    .perf_raw_cnt (perf_raw_cnt),
    .perf_cmp_cnt (perf_cmp_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tblFn(input logic [7:0] idx);
    return {24'hC0DE00, idx};
  endfunction

  // Table memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    tbl_data <= tbl_re ? tblFn(tbl_idx) : 32'h0;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pops and idle-zero invariants.
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_valid) begin
        if (expQ.size() == 0) checkVal("spurious_valid", 64'(cpu_valid), 64'd0);
        else checkVal("cpu_instr", 64'(cpu_instr), 64'(expQ.pop_front()));
      end else begin
        checkVal("instr_zero", 64'(cpu_instr), 64'd0);
      end
      if (!tbl_re) checkVal("idx_zero", 64'(tbl_idx), 64'd0);
    end
  end

  task automatic waitMemReq(input logic [31:0] expAddr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    checkVal("mem_req", 64'(mem_req), 64'd1);
    checkVal("mem_addr", 64'(mem_addr), 64'(expAddr));
  endtask

  task automatic fetchOne(input logic [31:0] expAddr, input logic [31:0] data, input int waits);
    cpu_req = 1'b1;
    waitMemReq(expAddr);
    repeat (waits) begin
      @(negedge clk);
      checkVal("addr_hold", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, expAddr});
    end
    @(posedge clk); #1;
    mem_ack  = 1'b1;
    mem_data = data;
    if (data[31]) expQ.push_back(tblFn(data[7:0]));
    else expQ.push_back(data);
    @(negedge clk);
    checkVal("ack_tbl_re", 64'(tbl_re), 64'(data[31]));
    if (data[31]) checkVal("tbl_idx0", 64'(tbl_idx), 64'(data[7:0]));
    checkVal("ack_no_valid", 64'(cpu_valid), 64'd0);
    @(posedge clk); #1;
    mem_ack  = 1'b0;
    mem_data = 32'h0;
    @(negedge clk);
    checkVal("valid_lat", 64'(cpu_valid), 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic secondHalf(input logic [7:0] idx);
    cpu_req = 1'b1;
    expQ.push_back(tblFn(idx));
    @(negedge clk);
    checkVal("hold_tbl_re", 64'(tbl_re), 64'd1);
    checkVal("tbl_idx1", 64'(tbl_idx), 64'(idx));
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("valid_lat1", 64'(cpu_valid), 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cpu_req = 1'b0; cpu_branch = 1'b0; cpu_target = 32'h0;
    mem_ack = 1'b0; mem_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_mem_req", 64'(mem_req), 64'd0);
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_valid", 64'(cpu_valid), 64'd0);
    checkVal("rst_tbl_re", 64'(tbl_re), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Raw fetch from reset PC, then compressed pair.
    fetchOne(32'h0000_0100, 32'h00A0_0013, 0);
    fetchOne(32'h0000_0104, 32'h8005_0003, 1);
    @(posedge clk); #1;
    secondHalf(8'h05);

    // Second pair, redirected while parked in HOLD with a simultaneous request.
    fetchOne(32'h0000_0108, 32'h8007_0009, 0);
    cpu_branch = 1'b1; cpu_target = 32'h0000_0200; cpu_req = 1'b1;
    @(negedge clk);
    checkVal("hold_br_tbl_re", 64'(tbl_re), 64'd0);
    @(posedge clk); #1;
    cpu_branch = 1'b0;
    fetchOne(32'h0000_0200, 32'h0000_0033, 0);

    // Redirect twice during a stalled fetch; the returned word must vanish.
    cpu_req = 1'b1;
    waitMemReq(32'h0000_0204);
    @(posedge clk); #1;
    cpu_branch = 1'b1; cpu_target = 32'h0000_02F0;
    @(posedge clk); #1;
    cpu_target = 32'h0000_0300;
    @(posedge clk); #1;
    cpu_branch = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_data = 32'h8001_0002;
    @(negedge clk);
    checkVal("redir_tbl_re", 64'(tbl_re), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_data = 32'h0;
    @(negedge clk);
    checkVal("redir_suppress", 64'(cpu_valid), 64'd0);
    checkVal("redir_idle", 64'(busy), 64'd0);
    fetchOne(32'h0000_0300, 32'h0000_0093, 2);

    // Asynchronous reset in the middle of a fetch.
    @(posedge clk); #1;
    cpu_req = 1'b1;
    waitMemReq(32'h0000_0304);
    #2;
    reset = 1'b0;
    #1;
    checkVal("async_mem_req", 64'(mem_req), 64'd0);
    checkVal("async_busy", 64'(busy), 64'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    fetchOne(32'h0000_0100, 32'h0000_0113, 0);

    // PC wrap at the top of the address space.
    @(posedge clk); #1;
    cpu_branch = 1'b1; cpu_target = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    cpu_branch = 1'b0;
`ifdef DECOMP_PERF_CNT_EN
    rawBase = perf_raw_cnt;
`endif
    fetchOne(32'hFFFF_FFFC, 32'h0000_0193, 0);
`ifdef DECOMP_PERF_CNT_EN
    checkVal("perf_raw_inc", 64'(perf_raw_cnt), 64'(rawBase + 32'd1));
`endif
    fetchOne(32'h0000_0000, 32'h0000_0213, 1);
`ifdef DECOMP_PERF_CNT_EN
    checkVal("perf_raw_inc2", 64'(perf_raw_cnt), 64'(rawBase + 32'd2));
`endif

    repeat (2) @(posedge clk);
    #1;
    checkVal("queue_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
